// File: rtl/demux_ser.sv
// Purpose: serialising demux; one MST_DWIDTH word in, NBEATS SYS_DWIDTH beats out on the selected channel.
// Latency: beat 0 is visible the cycle after the accepting edge; NBEATS cycles per word at full throughput.
// Backpressure: per-channel valid/ready; a beat holds while its sink is not ready, input ready only in the last-beat cycle.
module demux_ser #(
   parameter int MST_DWIDTH = 32,
   parameter int SYS_DWIDTH = 8,
   parameter int NUM_CH     = 3,
   parameter int MSB_FIRST  = 1,
   localparam int NBEATS    = MST_DWIDTH / SYS_DWIDTH,
   localparam int SELW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int CNTW      = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
   input  logic                         clk_sys,
   input  logic                         rst,
   input  logic [SELW-1:0]              select,
   input  logic [MST_DWIDTH-1:0]        data_i,
   input  logic                         valid_i,
   output logic                         ready_o,
   output logic [NUM_CH*SYS_DWIDTH-1:0] data_o,
   output logic [NUM_CH-1:0]            valid_o,
   input  logic [NUM_CH-1:0]            ready_i,
   output logic                         busy_o,
   output logic                         err_o
);

   typedef enum logic {IDLE, SHIFT} state_t;

   localparam logic [SELW:0]   NUM_CH_W = (SELW+1)'(NUM_CH);
   localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NBEATS - 1);

   state_t                  state_q;
   state_t                  state_d;
   logic [MST_DWIDTH-1:0]   word_q;
   logic [SELW-1:0]         ch_q;
   logic [CNTW-1:0]         cnt_q;
   logic                    err_q;

   logic                    sel_rdy;
   logic                    last_beat;
   logic                    xfer;
   logic                    accept;
   logic                    sel_ok;
   logic [SYS_DWIDTH-1:0]   beat;

   // Sink ready of the latched channel; other channels' ready is ignored.
   always_comb begin
      sel_rdy = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (ch_q == SELW'(k)) sel_rdy = ready_i[k];
      end
   end

   assign last_beat = (cnt_q == LAST_CNT);
   assign xfer      = (state_q == SHIFT) && sel_rdy;
   assign sel_ok    = ({1'b0, select} < NUM_CH_W);
   // Open for a new word when idle, or exactly when the last beat is leaving.
   assign ready_o   = (state_q == IDLE) || (last_beat && sel_rdy);
   assign accept    = valid_i && ready_o;
   // The working word is shifted after every transfer, so the current beat sits at a fixed end.
   assign beat      = (MSB_FIRST != 0) ? word_q[MST_DWIDTH-1 -: SYS_DWIDTH]
                                       : word_q[SYS_DWIDTH-1:0];
   assign busy_o    = (state_q == SHIFT);
   assign err_o     = err_q;

   // State register.
   always_ff @(posedge clk_sys) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state: a good accept enters SHIFT, the last transfer leaves it unless a new word chains in.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && sel_ok) state_d = SHIFT;
         SHIFT:   if (xfer && last_beat) state_d = (accept && sel_ok) ? SHIFT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: latch word/channel on a good accept, shift and count on each transfer, flag bad selects.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         word_q <= '0;
         ch_q   <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         err_q <= accept && !sel_ok;
         if (accept && sel_ok) begin
            word_q <= data_i;
            ch_q   <= select;
            cnt_q  <= '0;
         end else if (xfer) begin
            word_q <= (MSB_FIRST != 0) ? (word_q << SYS_DWIDTH) : (word_q >> SYS_DWIDTH);
            cnt_q  <= last_beat ? '0 : cnt_q + CNTW'(1);
         end
      end
   end

   // Drive only the latched channel while serialising; every other slice stays zero.
   always_comb begin
      valid_o = '0;
      data_o  = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if ((state_q == SHIFT) && (ch_q == SELW'(k))) begin
            valid_o[k]                          = 1'b1;
            data_o[k*SYS_DWIDTH +: SYS_DWIDTH]  = beat;
         end
      end
   end

endmodule

// File: tb/tb_demux_ser.sv
// Bench for demux_ser: default 32/8/3 MSB-first instance driven from a vector table,
// plus a 16/4 LSB-first instance and a single-beat (8/8) instance with hand-written sequences.
module tb_demux_ser;

   logic clk_sys = 1'b0;
   logic rst;

   always #5 clk_sys = ~clk_sys;

   // Instance A: MST 32, SYS 8, 3 channels, MSB first
   logic [1:0]  a_sel;
   logic [31:0] a_dat;
   logic        a_vld;
   logic        a_rdy_o;
   logic [23:0] a_data_o;
   logic [2:0]  a_valid_o;
   logic [2:0]  a_rdy;
   logic        a_busy;
   logic        a_err;

   // Instance B: MST 16, SYS 4, 3 channels, LSB first
   logic [1:0]  b_sel;
   logic [15:0] b_dat;
   logic        b_vld;
   logic        b_rdy_o;
   logic [11:0] b_data_o;
   logic [2:0]  b_valid_o;
   logic [2:0]  b_rdy;
   logic        b_busy;
   logic        b_err;

   // Instance C: MST 8, SYS 8 (one beat), 2 channels
   logic        c_sel;
   logic [7:0]  c_dat;
   logic        c_vld;
   logic        c_rdy_o;
   logic [15:0] c_data_o;
   logic [1:0]  c_valid_o;
   logic [1:0]  c_rdy;
   logic        c_busy;
   logic        c_err;

   demux_ser #(.MST_DWIDTH(32), .SYS_DWIDTH(8), .NUM_CH(3), .MSB_FIRST(1)) dut_a (
      .clk_sys(clk_sys), .rst(rst), .select(a_sel), .data_i(a_dat), .valid_i(a_vld),
      .ready_o(a_rdy_o), .data_o(a_data_o), .valid_o(a_valid_o), .ready_i(a_rdy),
      .busy_o(a_busy), .err_o(a_err));

   demux_ser #(.MST_DWIDTH(16), .SYS_DWIDTH(4), .NUM_CH(3), .MSB_FIRST(0)) dut_b (
      .clk_sys(clk_sys), .rst(rst), .select(b_sel), .data_i(b_dat), .valid_i(b_vld),
      .ready_o(b_rdy_o), .data_o(b_data_o), .valid_o(b_valid_o), .ready_i(b_rdy),
      .busy_o(b_busy), .err_o(b_err));

   demux_ser #(.MST_DWIDTH(8), .SYS_DWIDTH(8), .NUM_CH(2), .MSB_FIRST(1)) dut_c (
      .clk_sys(clk_sys), .rst(rst), .select(c_sel), .data_i(c_dat), .valid_i(c_vld),
      .ready_o(c_rdy_o), .data_o(c_data_o), .valid_o(c_valid_o), .ready_i(c_rdy),
      .busy_o(c_busy), .err_o(c_err));

   typedef struct {
      logic        rst;
      logic [1:0]  sel;
      logic [31:0] dat;
      logic        vld;
      logic [2:0]  rdy;
      logic [2:0]  e_valid;
      logic [23:0] e_data;
      logic        e_rdy;
      logic        e_busy;
      logic        e_err;
   } vec_t;

   vec_t tbl[$];
   int   n_chk = 0;
   int   n_err = 0;

   task automatic add(input logic r, input logic [1:0] s, input logic [31:0] d, input logic v,
                      input logic [2:0] rd, input logic [2:0] ev, input logic [23:0] ed,
                      input logic er, input logic eb, input logic ee);
      vec_t x;
      x.rst = r; x.sel = s; x.dat = d; x.vld = v; x.rdy = rd;
      x.e_valid = ev; x.e_data = ed; x.e_rdy = er; x.e_busy = eb; x.e_err = ee;
      tbl.push_back(x);
   endtask

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      a_sel = '0; a_dat = '0; a_vld = 1'b0; a_rdy = 3'b111;
      b_sel = '0; b_dat = '0; b_vld = 1'b0; b_rdy = 3'b111;
      c_sel = 1'b0; c_dat = '0; c_vld = 1'b0; c_rdy = 2'b11;

      //  rst sel  data          vld rdy      e_valid e_data      rdy busy err
      // Basic word to ch1
      add(0, 1, 32'hA1B2C3D4, 1, 3'b111, 3'b000, 24'h000000, 1, 0, 0);
      add(0, 1, 32'hA1B2C3D4, 0, 3'b111, 3'b010, 24'h00A100, 0, 1, 0);
      add(0, 1, 32'hA1B2C3D4, 0, 3'b111, 3'b010, 24'h00B200, 0, 1, 0);
      add(0, 1, 32'hA1B2C3D4, 0, 3'b111, 3'b010, 24'h00C300, 0, 1, 0);
      add(0, 1, 32'hA1B2C3D4, 0, 3'b111, 3'b010, 24'h00D400, 1, 1, 0);
      // Backpressure: B2 held three extra cycles, other channels' ready ignored
      add(0, 1, 32'hA1B2C3D4, 1, 3'b111, 3'b000, 24'h000000, 1, 0, 0);
      add(0, 1, 32'hA1B2C3D4, 0, 3'b111, 3'b010, 24'h00A100, 0, 1, 0);
      add(0, 1, 32'hA1B2C3D4, 0, 3'b101, 3'b010, 24'h00B200, 0, 1, 0);
      add(0, 1, 32'hA1B2C3D4, 0, 3'b101, 3'b010, 24'h00B200, 0, 1, 0);
      add(0, 1, 32'hA1B2C3D4, 0, 3'b101, 3'b010, 24'h00B200, 0, 1, 0);
      add(0, 1, 32'hA1B2C3D4, 0, 3'b111, 3'b010, 24'h00B200, 0, 1, 0);
      add(0, 1, 32'hA1B2C3D4, 0, 3'b010, 3'b010, 24'h00C300, 0, 1, 0);
      // Last beat stalled: pending word must not be taken
      add(0, 0, 32'h11223344, 1, 3'b101, 3'b010, 24'h00D400, 0, 1, 0);
      // Back-to-back: accept coincides with last transfer
      add(0, 0, 32'h11223344, 1, 3'b111, 3'b010, 24'h00D400, 1, 1, 0);
      add(0, 2, 32'h55667788, 1, 3'b111, 3'b001, 24'h000011, 0, 1, 0);
      add(0, 2, 32'h55667788, 1, 3'b111, 3'b001, 24'h000022, 0, 1, 0);
      add(0, 2, 32'h55667788, 1, 3'b111, 3'b001, 24'h000033, 0, 1, 0);
      add(0, 2, 32'h55667788, 1, 3'b111, 3'b001, 24'h000044, 1, 1, 0);
      add(0, 2, 32'h55667788, 0, 3'b111, 3'b100, 24'h550000, 0, 1, 0);
      add(0, 2, 32'h55667788, 0, 3'b111, 3'b100, 24'h660000, 0, 1, 0);
      add(0, 2, 32'h55667788, 0, 3'b111, 3'b100, 24'h770000, 0, 1, 0);
      add(0, 2, 32'h55667788, 0, 3'b111, 3'b100, 24'h880000, 1, 1, 0);
      // Bad select
      add(0, 3, 32'hDEADBEEF, 1, 3'b111, 3'b000, 24'h000000, 1, 0, 0);
      add(0, 3, 32'hDEADBEEF, 0, 3'b111, 3'b000, 24'h000000, 1, 0, 1);
      add(0, 3, 32'hDEADBEEF, 0, 3'b111, 3'b000, 24'h000000, 1, 0, 0);
      // Reset mid-word, then a fresh word starts at beat 0
      add(0, 0, 32'h01020304, 1, 3'b111, 3'b000, 24'h000000, 1, 0, 0);
      add(0, 0, 32'h01020304, 0, 3'b111, 3'b001, 24'h000001, 0, 1, 0);
      add(1, 0, 32'h01020304, 0, 3'b111, 3'b001, 24'h000002, 0, 1, 0);
      add(1, 0, 32'h01020304, 0, 3'b111, 3'b000, 24'h000000, 1, 0, 0);
      add(0, 2, 32'hCAFEF00D, 1, 3'b111, 3'b000, 24'h000000, 1, 0, 0);
      add(0, 2, 32'hCAFEF00D, 0, 3'b111, 3'b100, 24'hCA0000, 0, 1, 0);
      add(0, 2, 32'hCAFEF00D, 0, 3'b111, 3'b100, 24'hFE0000, 0, 1, 0);
      add(0, 2, 32'hCAFEF00D, 0, 3'b111, 3'b100, 24'hF00000, 0, 1, 0);
      add(0, 2, 32'hCAFEF00D, 0, 3'b111, 3'b100, 24'h0D0000, 1, 1, 0);
      add(0, 2, 32'hCAFEF00D, 0, 3'b111, 3'b000, 24'h000000, 1, 0, 0);

      repeat (2) @(posedge clk_sys);

      foreach (tbl[i]) begin
         @(negedge clk_sys);
         rst   = tbl[i].rst;
         a_sel = tbl[i].sel;
         a_dat = tbl[i].dat;
         a_vld = tbl[i].vld;
         a_rdy = tbl[i].rdy;
         #1;
         chk("a_valid_o", i, 32'(a_valid_o), 32'(tbl[i].e_valid));
         chk("a_data_o",  i, 32'(a_data_o),  32'(tbl[i].e_data));
         chk("a_ready_o", i, 32'(a_rdy_o),   32'(tbl[i].e_rdy));
         chk("a_busy_o",  i, 32'(a_busy),    32'(tbl[i].e_busy));
         chk("a_err_o",   i, 32'(a_err),     32'(tbl[i].e_err));
      end

      // LSB-first 16/4: ABCD to ch0 -> D, C, B, A
      @(negedge clk_sys);
      a_vld = 1'b0;
      b_sel = 2'd0; b_dat = 16'hABCD; b_vld = 1'b1; b_rdy = 3'b111;
      #1;
      chk("b_ready_idle", 0, 32'(b_rdy_o), 32'h1);
      chk("b_valid_idle", 0, 32'(b_valid_o), 32'h0);
      @(negedge clk_sys);
      b_vld = 1'b0;
      #1;
      chk("b_beat0", 1, 32'(b_data_o), 32'h00D);
      chk("b_valid", 1, 32'(b_valid_o), 32'h1);
      @(negedge clk_sys); #1;
      chk("b_beat1", 2, 32'(b_data_o), 32'h00C);
      @(negedge clk_sys); #1;
      chk("b_beat2", 3, 32'(b_data_o), 32'h00B);
      chk("b_ready_mid", 3, 32'(b_rdy_o), 32'h0);
      @(negedge clk_sys); #1;
      chk("b_beat3", 4, 32'(b_data_o), 32'h00A);
      chk("b_ready_last", 4, 32'(b_rdy_o), 32'h1);
      @(negedge clk_sys); #1;
      chk("b_valid_done", 5, 32'(b_valid_o), 32'h0);
      chk("b_busy_done", 5, 32'(b_busy), 32'h0);

      // Single-beat 8/8: ready_o follows the selected sink's ready while in SHIFT
      @(negedge clk_sys);
      c_sel = 1'b1; c_dat = 8'h5A; c_vld = 1'b1; c_rdy = 2'b01;
      #1;
      chk("c_ready_idle", 0, 32'(c_rdy_o), 32'h1);
      @(negedge clk_sys);
      c_sel = 1'b0; c_dat = 8'hC3; c_vld = 1'b1; c_rdy = 2'b01;
      #1;
      chk("c_valid", 1, 32'(c_valid_o), 32'h2);
      chk("c_data", 1, 32'(c_data_o), 32'h5A00);
      chk("c_ready_stall", 1, 32'(c_rdy_o), 32'h0);
      chk("c_busy", 1, 32'(c_busy), 32'h1);
      @(negedge clk_sys);
      c_rdy = 2'b11;
      #1;
      chk("c_data_hold", 2, 32'(c_data_o), 32'h5A00);
      chk("c_ready_go", 2, 32'(c_rdy_o), 32'h1);
      @(negedge clk_sys);
      c_vld = 1'b0;
      #1;
      chk("c_valid2", 3, 32'(c_valid_o), 32'h1);
      chk("c_data2", 3, 32'(c_data_o), 32'h00C3);
      @(negedge clk_sys); #1;
      chk("c_valid_done", 4, 32'(c_valid_o), 32'h0);
      chk("c_busy_done", 4, 32'(c_busy), 32'h0);
      chk("c_err", 4, 32'(c_err), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
